ps2_kbd_interface: RTL and testbench



---
 rtl/ps2_kbd_interface.sv | 174 +++++++++++++++++
 tb/tb_ps2_kbd_interface.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_interface.sv
// rtl/ps2_kbd_interface.sv - PS/2 keyboard receiver with make-code filter, 7-seg digits and slow tick
// Optional feature macro: PS2_PARITY_CHECK_EN (odd parity over data + parity bit)
module ps2_kbd_interface #(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int TICK_HZ        = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire        ps2_clk,
    inout  wire        ps2_dat,
    output logic [7:0] key_data,
    output logic       key_pressed,
    output logic [7:0] last_data,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic       tick_1hz
);

    localparam int DIV = CLK_FREQ_HZ / (2 * TICK_HZ);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic [TW-1:0] idle_cnt;
    logic          brk;
    logic [DW-1:0] div_cnt;

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;
    logic frame_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
`endif

    // The PS/2 lines are only ever observed; the device and the pull-ups own them.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = dat_s2 & (^{par_bit, shift_reg});
`else
    assign frame_ok = dat_s2;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shift_reg   <= 8'h00;
            idle_cnt    <= '0;
            brk         <= 1'b0;
            key_data    <= 8'h00;
            key_pressed <= 1'b0;
            last_data   <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            key_pressed <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    bit_cnt  <= 4'd0;
                    if (fall && !dat_s2) begin
                        state <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (fall) begin
                        idle_cnt <= '0;
                        if (bit_cnt < 4'd8) begin
                            shift_reg <= {dat_s2, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (bit_cnt == 4'd8) begin
`ifdef PS2_PARITY_CHECK_EN
                            par_bit <= dat_s2;
`endif
                            bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            // Stop bit: the frame ends here whether or not it is kept.
                            state   <= IDLE;
                            bit_cnt <= 4'd0;
                            if (frame_ok) begin
                                key_data    <= shift_reg;
                                key_pressed <= 1'b1;
                                if (shift_reg == 8'hF0) begin
                                    brk <= 1'b1;
                                end else if (shift_reg == 8'hE0) begin
                                    brk <= brk;
                                end else if (brk) begin
                                    brk <= 1'b0;
                                end else begin
                                    last_data <= shift_reg;
                                end
                            end
                        end
                    end else if (idle_cnt == TO_LAST) begin
                        state    <= IDLE;
                        bit_cnt  <= 4'd0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt  <= '0;
            tick_1hz <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            tick_1hz <= ~tick_1hz;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign hex0 = seg7(last_data[3:0]);
    assign hex1 = seg7(last_data[7:4]);

endmodule

// File: tb/tb_ps2_kbd_interface.sv
// tb/tb_ps2_kbd_interface.sv - directed self-checking bench for ps2_kbd_interface
module tb_ps2_kbd_interface;

    localparam int TO = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clk_drv = 1'b1;
    logic       dat_drv = 1'b1;
    wire        ps2_clk = clk_drv;
    wire        ps2_dat = dat_drv;
    logic [7:0] key_data;
    logic       key_pressed;
    logic [7:0] last_data;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic       tick_1hz;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int base;

    ps2_kbd_interface #(
        .CLK_FREQ_HZ(10),
        .TICK_HZ(1),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .key_data(key_data),
        .key_pressed(key_pressed),
        .last_data(last_data),
        .hex0(hex0),
        .hex1(hex1),
        .tick_1hz(tick_1hz)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (key_pressed) strobes++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clock) dat_drv = b;
        repeat (4) @(negedge clock);
        clk_drv = 1'b0;
        repeat (8) @(negedge clock);
        clk_drv = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        dat_drv = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    initial begin
        repeat (4) @(negedge clock);
        check("rst_key_data", key_data, 8'h00);
        check("rst_key_pressed", key_pressed, 1'b0);
        check("rst_last_data", last_data, 8'h00);
        check("rst_hex0", hex0, 7'h40);
        check("rst_hex1", hex1, 7'h40);
        check("rst_tick", tick_1hz, 1'b0);
        reset = 1'b0;

        // Divider of 5: toggles on the 5th, 10th, 15th rising edge after release.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (k == 4 || k == 5 || k == 9 || k == 10 || k == 14 || k == 15)
                check($sformatf("tick_k%0d", k), tick_1hz, (k / 5) % 2);
        end

        base = strobes;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("f1c_strobes", strobes - base, 1);
        check("f1c_key_data", key_data, 8'h1C);
        check("f1c_last_data", last_data, 8'h1C);
        check("f1c_hex0", hex0, 7'h46);
        check("f1c_hex1", hex1, 7'h79);

        base = strobes;
        send_frame(8'hF0, 1'b1, 1'b1);
        check("brk_last_after_f0", last_data, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("brk_strobes", strobes - base, 2);
        check("brk_key_data", key_data, 8'h1C);
        check("brk_last_data", last_data, 8'h1C);
        send_frame(8'h29, 1'b0, 1'b1);
        check("f29_key_data", key_data, 8'h29);
        check("f29_last_data", last_data, 8'h29);
        check("f29_hex0", hex0, 7'h10);
        check("f29_hex1", hex1, 7'h24);

        base = strobes;
        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("par_strobes", strobes - base, 0);
        check("par_key_data", key_data, 8'h29);
        check("par_last_data", last_data, 8'h29);
`else
        check("par_strobes", strobes - base, 1);
        check("par_key_data", key_data, 8'h1C);
        check("par_last_data", last_data, 8'h1C);
`endif

        base = strobes;
        send_frame(8'h45, 1'b0, 1'b0);
        check("badstop_strobes", strobes - base, 0);

        base = strobes;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        dat_drv = 1'b1;
        repeat (TO + 1) @(negedge clock);
        check("to_no_strobe", strobes - base, 0);
        send_frame(8'h66, 1'b1, 1'b1);
        check("to_strobes", strobes - base, 1);
        check("to_key_data", key_data, 8'h66);
        check("to_last_data", last_data, 8'h66);

        base = strobes;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        dat_drv = 1'b1;
        repeat (TO + 10) @(negedge clock);
        check("rstmid_strobes", strobes - base, 0);
        check("rstmid_key_data", key_data, 8'h00);
        check("rstmid_last_data", last_data, 8'h00);
        send_frame(8'h16, 1'b0, 1'b1);
        check("rec_strobes", strobes - base, 1);
        check("rec_key_data", key_data, 8'h16);
        check("rec_hex0", hex0, 7'h02);
        check("rec_hex1", hex1, 7'h79);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
